// File: rtl/param_frame_rx.sv
// rtl/param_frame_rx.sv - UART parameter-frame receiver with atomic commit
// Optional XOR checksum byte and CHECK state: define PARAM_CHECKSUM_EN.
module param_frame_rx #(
  parameter int unsigned REG_SIZE       = 14,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_error,
  output logic [8*REG_SIZE-1:0] params,
  output logic                  param_load,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned   W              = 8 * REG_SIZE;
  localparam logic [111:0]  DEFAULT_PARAMS = 112'hC000_14CD_7240_6A00_5555_7300_0400;
  localparam logic [W-1:0]  PARAM_RESET    = W'(DEFAULT_PARAMS);
  localparam logic [3:0]    LAST_IDX       = 4'(REG_SIZE - 1);
  localparam logic [15:0]   GAP_LIMIT      = 16'(TIMEOUT_CYCLES - 1);

`ifdef PARAM_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_t;
  logic [7:0]   xor_q;
`else
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD} state_t;
`endif

  state_t       state_q;
  logic [3:0]   idx_q;
  logic [15:0]  gap_q;
  logic [W-1:0] shadow_q;
  logic [W-1:0] shadow_d;
  logic [W-1:0] params_q;
  logic         load_q;
  logic         err_q;

  // Shadow buffer with the current byte dropped into slot idx_q (byte 0 at the MSBs).
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < int'(REG_SIZE); i++) begin
      if (idx_q == 4'(i)) begin
        shadow_d[W-8-8*i +: 8] = rx_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      gap_q    <= 16'd0;
      shadow_q <= '0;
      params_q <= PARAM_RESET;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
      xor_q    <= 8'd0;
`endif
    end else begin
      load_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_valid && rx_byte == SYNC_BYTE) begin
            state_q <= S_PAYLOAD;
            idx_q   <= 4'd0;
            gap_q   <= 16'd0;
`ifdef PARAM_CHECKSUM_EN
            xor_q   <= 8'd0;
`endif
          end
        end

        S_PAYLOAD: begin
          if (rx_error) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            gap_q   <= 16'd0;
          end else if (rx_valid) begin
            shadow_q <= shadow_d;
            idx_q    <= idx_q + 4'd1;
            gap_q    <= 16'd0;
`ifdef PARAM_CHECKSUM_EN
            xor_q    <= xor_q ^ rx_byte;
            if (idx_q == LAST_IDX) begin
              state_q <= S_CHECK;
            end
`else
            // Last byte: commit the merged buffer on this same edge.
            if (idx_q == LAST_IDX) begin
              params_q <= shadow_d;
              load_q   <= 1'b1;
              state_q  <= S_IDLE;
            end
`endif
          end else if (gap_q == GAP_LIMIT) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            gap_q   <= 16'd0;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end

`ifdef PARAM_CHECKSUM_EN
        S_CHECK: begin
          if (rx_error) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            gap_q   <= 16'd0;
          end else if (rx_valid) begin
            if (rx_byte == xor_q) begin
              params_q <= shadow_q;
              load_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= S_IDLE;
            gap_q   <= 16'd0;
          end else if (gap_q == GAP_LIMIT) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            gap_q   <= 16'd0;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign params     = params_q;
  assign param_load = load_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_param_frame_rx.sv
// tb/tb_param_frame_rx.sv - directed self-checking bench for param_frame_rx
module tb_param_frame_rx;

  localparam int            TO  = 20;
  localparam logic [111:0]  DEF = 112'hC00014CD72406A00555573000400;
  localparam logic [111:0]  F1  = 112'h0102030405060708090A0B0C0D0E;
  localparam logic [111:0]  F2  = 112'h101112131415161718191A1B1C1D;
  localparam logic [111:0]  F3  = 112'hFEDCBA9876543210A5A50F1E2D3C;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic         rx_error;
  logic [111:0] params;
  logic         param_load;
  logic         frame_err;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int loads = 0;
  int errs  = 0;
  int both  = 0;
  int l0;
  int e0;

  param_frame_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_error   (rx_error),
    .params     (params),
    .param_load (param_load),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (param_load === 1'b1) loads++;
    if (frame_err === 1'b1) errs++;
    if (param_load === 1'b1 && frame_err === 1'b1) both++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] xor_of(input logic [111:0] d);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 14; i++) x ^= d[111-8*i -: 8];
    return x;
  endfunction

  task automatic send_payload(input logic [111:0] d);
    for (int i = 0; i < 14; i++) send(d[111-8*i -: 8]);
  endtask

  task automatic send_frame(input logic [111:0] d);
    send(8'hA5);
    send_payload(d);
`ifdef PARAM_CHECKSUM_EN
    send(xor_of(d));
`endif
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; rx_error = 1'b0;
    idle(3);
    chk("rst_params", params, DEF);
    chk("rst_load", param_load, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(1);

    // Non-sync bytes in IDLE are ignored.
    send(8'h00); chk("junk00_busy", busy, 1'b0);
    send(8'hFF); chk("junkFF_busy", busy, 1'b0);
    send(8'h3C); chk("junk3C_busy", busy, 1'b0);
    idle(1);
    chk("junk_pulses", loads + errs, 0);

`ifdef PARAM_CHECKSUM_EN
    e0 = errs; l0 = loads;
    send(8'hA5);
    send_payload(F1);
    chk("pre_ck_busy", busy, 1'b1);
    chk("pre_ck_params", params, DEF);
    chk("f1_xor_is_0f", xor_of(F1), 8'h0F);
    send(8'h10);
    chk("badck_err", frame_err, 1'b1);
    chk("badck_load", param_load, 1'b0);
    chk("badck_busy", busy, 1'b0);
    chk("badck_params", params, DEF);
    idle(2);
    chk("badck_err_cnt", errs - e0, 1);
    chk("badck_load_cnt", loads - l0, 0);
`endif

    l0 = loads;
    send_frame(F1);
    chk("f1_load", param_load, 1'b1);
    chk("f1_params", params, F1);
    chk("f1_busy", busy, 1'b0);
    idle(2);
    chk("f1_load_cnt", loads - l0, 1);

    // Inter-byte timeout.
    e0 = errs; l0 = loads;
    send(8'hA5);
    for (int i = 0; i < 5; i++) send(8'h55);
    idle(TO - 1);
    chk("to_early_busy", busy, 1'b1);
    chk("to_early_err", frame_err, 1'b0);
    idle(1);
    chk("to_err", frame_err, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_params", params, F1);
    idle(1);
    chk("to_err_cnt", errs - e0, 1);
    send_frame(F2);
    chk("after_to_load", param_load, 1'b1);
    chk("after_to_params", params, F2);
    idle(2);
    chk("after_to_load_cnt", loads - l0, 1);

    // rx_error coincident with rx_valid aborts.
    e0 = errs; l0 = loads;
    send(8'hA5);
    for (int i = 0; i < 3; i++) send(8'h33);
    rx_error = 1'b1; rx_valid = 1'b1; rx_byte = 8'h77;
    @(posedge clk); #1;
    rx_error = 1'b0; rx_valid = 1'b0;
    chk("rxerr_err", frame_err, 1'b1);
    chk("rxerr_busy", busy, 1'b0);
    chk("rxerr_params", params, F2);
    idle(2);
    chk("rxerr_cnts", {errs - e0, loads - l0}, {32'd1, 32'd0});

    // Reset mid-frame: silent discard, defaults restored.
    e0 = errs; l0 = loads;
    send(8'hA5);
    for (int i = 0; i < 4; i++) send(8'h44);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_params", params, DEF);
    idle(2);
    chk("midrst_pulses", (errs - e0) + (loads - l0), 0);

    // Back-to-back frames with no idle cycle; F3 carries A5 as data.
    l0 = loads;
    send_frame(F1);
    chk("b2b_first_load", param_load, 1'b1);
    chk("b2b_first_params", params, F1);
    send_frame(F3);
    chk("b2b_second_params", params, F3);
    idle(2);
    chk("b2b_load_cnt", loads - l0, 2);
    chk("load_err_overlap", both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_frame_rx.md
PARAM_FRAME_RX -- requirements
Module: param_frame_rx

Interface
REQ-001 SHALL provide parameter REG_SIZE, default 14, the number of payload bytes per frame.
REQ-002 SHALL provide parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 65535, the maximum clk cycles allowed between bytes inside a frame.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx_valid  input  1  one-cycle strobe: rx_byte holds a received UART byte.
REQ-007 rx_byte  input  8  received byte, sampled only when rx_valid=1.
REQ-008 rx_error  input  1  one-cycle strobe: the UART receiver flagged a framing error.
REQ-009 params  output  8*REG_SIZE  committed parameter file; payload byte 0 in the MSBs [111:104], byte 13 in the LSBs [7:0].
REQ-010 param_load  output  1  one-cycle pulse in the cycle params takes a new value.
REQ-011 frame_err  output  1  one-cycle pulse when a frame is discarded.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement the states IDLE, PAYLOAD and CHECK; CHECK exists only when PARAM_CHECKSUM_EN is defined.
REQ-014 In IDLE, an rx_valid byte equal to SYNC_BYTE SHALL move the block to PAYLOAD and clear the byte index (4 bits) and the running XOR; all other bytes and rx_error are ignored.
REQ-015 In PAYLOAD, each rx_valid byte SHALL be written to shadow[index]; index increments, and the running XOR is updated. SYNC_BYTE values here are data.
REQ-016 After byte REG_SIZE-1 is accepted, the block SHALL go to CHECK when the checksum is enabled, or commit otherwise.
REQ-017 Commit: on the clock edge after the final byte is accepted, params SHALL equal the full shadow buffer, param_load=1 for one cycle, and the state returns to IDLE. The update is atomic: params never shows a partial frame.
REQ-018 In CHECK, if rx_byte equals the XOR of the REG_SIZE payload bytes, the block SHALL commit per REQ-017. On mismatch it SHALL pulse frame_err, leave params unchanged and return to IDLE.
REQ-019 A 16-bit gap counter SHALL clear on every rx_valid and increment each cycle in PAYLOAD/CHECK. When it reaches TIMEOUT_CYCLES, the block SHALL pulse frame_err, discard the shadow buffer and return to IDLE.
REQ-020 rx_error in PAYLOAD/CHECK SHALL abort the frame: frame_err pulse, return to IDLE, params unchanged. If rx_error and rx_valid occur in the same cycle, rx_error wins and the byte is dropped.
REQ-021 param_load and frame_err SHALL never be high in the same cycle.
REQ-022 A new SYNC_BYTE arriving in the cycle immediately after a commit or abort SHALL be accepted as a new frame start (zero dead cycles).

Reset
REQ-023 On rst, the block SHALL go to IDLE with index, XOR, gap counter, param_load, frame_err and busy all at 0.
REQ-024 On rst, params SHALL load the defaults C000 14CD 7240 6A00 5555 7300 0400 (icx=-1.0, icy=0.1, icz=25.0, sigma=10.0, beta=8/3, rho=28.0, dt=1/256), MSB first.
REQ-025 rst asserted mid-frame SHALL discard the frame without pulsing frame_err or param_load.

Configuration
REQ-026 When macro PARAM_CHECKSUM_EN is defined, the frame SHALL be SYNC + REG_SIZE bytes + 1 XOR checksum byte, validated per REQ-018.
REQ-027 When PARAM_CHECKSUM_EN is undefined, the frame SHALL be SYNC + REG_SIZE bytes, committed with no checksum; CHECK state and the XOR logic SHALL be absent.

Verification
REQ-028 Reset -> params=0xC00014CD72406A00555573000400, param_load=0, busy=0.
REQ-029 With the checksum enabled: send A5, 01..0E, 0F -> one cycle after the last byte, params=0x0102030405060708090A0B0C0D0E, param_load pulses once.
REQ-030 Same frame with checksum 0x10 -> frame_err pulses once, params retain the reset defaults, busy=0.
REQ-031 Send A5 and 5 bytes, then hold rx_valid low for TIMEOUT_CYCLES cycles -> frame_err pulse, IDLE. A following full valid frame commits normally.
REQ-032 Send A5 and 3 bytes, then rx_error coincident with rx_valid -> frame_err. Assert rst mid-frame on a second attempt -> no pulses and params = defaults.
REQ-033 Bytes 00, FF, 3C in IDLE -> no state change. Back-to-back frames with zero idle cycles -> two param_load pulses, and params holds the second frame.
